// File: rtl/config_loader.sv
// Serial bitstream loader: feeds one config_tile shift chain, MSB-first.
// Optional readback capture from the chain tail under CONFIG_LOADER_READBACK_EN.
module config_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 14,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_bit,
  output logic              cfg_shift,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
`ifdef CONFIG_LOADER_READBACK_EN
  ,
  input  logic              cfg_return,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int WC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WC_W-1:0]   wcnt;
  logic              last_bit;
  logic              word_end;
  logic              go;
  logic              kill;

  assign last_bit = (bit_count == CNT_W'(CHAIN_LEN));
  assign word_end = (wcnt == WC_W'(WORD_W));
  assign go       = (state == S_IDLE) && start && !abort;
  assign kill     = (state != S_IDLE) && abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      wcnt      <= '0;
      in_ready  <= 1'b0;
      cfg_bit   <= 1'b0;
      cfg_shift <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        // partial bit_count is kept for debug
        state     <= S_IDLE;
        shreg     <= '0;
        wcnt      <= '0;
        in_ready  <= 1'b0;
        cfg_bit   <= 1'b0;
        cfg_shift <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (go) begin
              state     <= S_WAIT;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              bit_count <= '0;
            end
          end
          S_WAIT: begin
            if (in_valid) begin
              state     <= S_SHIFT;
              in_ready  <= 1'b0;
              cfg_shift <= 1'b1;
              cfg_bit   <= in_data[WORD_W-1];
              shreg     <= {in_data[WORD_W-2:0], 1'b0};
              bit_count <= bit_count + 1'b1;
              wcnt      <= WC_W'(1);
            end
          end
          S_SHIFT: begin
            if (last_bit) begin
              state     <= S_DONE;
              cfg_shift <= 1'b0;
              cfg_bit   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              shreg     <= '0;
            end else if (word_end) begin
              state     <= S_WAIT;
              cfg_shift <= 1'b0;
              cfg_bit   <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              cfg_bit   <= shreg[WORD_W-1];
              shreg     <= {shreg[WORD_W-2:0], 1'b0};
              bit_count <= bit_count + 1'b1;
              wcnt      <= wcnt + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef CONFIG_LOADER_READBACK_EN
  localparam int PW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [PW-1:0] TOP = PW'(WORD_W - 1);

  logic [WORD_W-1:0] rb_acc;
  logic [WORD_W-1:0] rb_next;
  logic [PW-1:0]     rb_pos;

  // bits land at a descending position, so partial words come out left-aligned
  always_comb begin
    rb_next         = rb_acc;
    rb_next[rb_pos] = cfg_return;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_acc   <= '0;
      rb_pos   <= TOP;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (go || kill) begin
        rb_acc <= '0;
        rb_pos <= TOP;
      end else if (cfg_shift) begin
        if (rb_pos == '0 || last_bit) begin
          rb_data  <= rb_next;
          rb_valid <= 1'b1;
          rb_acc   <= '0;
          rb_pos   <= TOP;
        end else begin
          rb_acc <= rb_next;
          rb_pos <= rb_pos - 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader (WORD_W=8, CHAIN_LEN=14).
// Readback checks are built when CONFIG_LOADER_READBACK_EN is defined.
module tb_config_loader;
  localparam int W  = 8;
  localparam int L  = 14;
  localparam int CW = $clog2(L + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          cfg_bit;
  logic          cfg_shift;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;
`ifdef CONFIG_LOADER_READBACK_EN
  logic          cfg_return;
  logic [W-1:0]  rb_data;
  logic          rb_valid;
  logic [L-1:0]  chain = '0;
  assign cfg_return = chain[L-1];
  always @(posedge clk) if (cfg_shift) chain <= {chain[L-2:0], cfg_bit};
`endif

  config_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cfg_bit(cfg_bit),
    .cfg_shift(cfg_shift),
    .busy(busy),
    .done(done),
    .bit_count(bit_count)
`ifdef CONFIG_LOADER_READBACK_EN
    ,
    .cfg_return(cfg_return),
    .rb_data(rb_data),
    .rb_valid(rb_valid)
`endif
  );

  always #5 clk = ~clk;

  int       n_run = 0;
  int       n_fail = 0;
  int       n_shift = 0;
  int       n_done = 0;
  int       sent_bits = 0;
  bit       q_exp[$];
  logic [W-1:0] rb_q[$];
  bit       rb_en = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_shift) begin
        n_shift++;
        if (q_exp.size() == 0) chk("extra_bit", cfg_shift, 0);
        else chk("cfg_bit", cfg_bit, q_exp.pop_front());
        chk("rdy_in_shift", in_ready, 0);
      end
      if (done) n_done++;
`ifdef CONFIG_LOADER_READBACK_EN
      if (rb_en && rb_valid) begin
        if (rb_q.size() == 0) chk("extra_rb", rb_valid, 0);
        else chk("rb_data", rb_data, rb_q.pop_front());
      end
`endif
    end
  end

  task automatic push_word(logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      if (sent_bits < L) begin
        q_exp.push_back(w[i]);
        sent_bits++;
      end
    end
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sent_bits = 0;
    n_shift = 0;
    n_done = 0;
  endtask

  task automatic send_one(logic [W-1:0] w, bit hold);
    int k = 0;
    in_data = w;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_seen", in_ready, 1);
    push_word(w);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
  endtask

  task automatic full_load(bit hold);
    start_load();
    chk("cnt_clr", bit_count, 0);
    send_one(8'hA5, hold);
    send_one(8'hC3, hold);
    in_valid = 1'b0;
    wait_done();
    chk("n_shift", n_shift, L);
    chk("n_done", n_done, 1);
    chk("bits_left", q_exp.size(), 0);
    chk("cnt_final", bit_count, L);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_shift", cfg_shift, 0);
    chk("rst_cnt", bit_count, 0);
`ifdef CONFIG_LOADER_READBACK_EN
    chk("rst_rb", {rb_valid, rb_data}, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // async reset while shifting
    start_load();
    send_one(8'hA5, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_shift", cfg_shift, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_shift", cfg_shift, 0);
    chk("ar_bit", cfg_bit, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", in_ready, 0);
    chk("ar_done", done, 0);
    chk("ar_cnt", bit_count, 0);
    q_exp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_idle", in_ready, 0);

    full_load(1'b0);
    repeat (2) @(negedge clk);
    chk("cnt_hold", bit_count, L);

    full_load(1'b1);

    // abort after 5 bits
    start_load();
    send_one(8'hA5, 1'b0);
    for (int k = 0; k < 20 && bit_count != 5; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_shift", cfg_shift, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ready", in_ready, 0);
    chk("ab_cnt", bit_count, 5);
    q_exp.delete();
    repeat (3) @(negedge clk);
    chk("ab_nodone", n_done, 0);
    chk("ab_cnt_hold", bit_count, 5);
    full_load(1'b0);

    // start during SHIFT is ignored
    start_load();
    send_one(8'hA5, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("st_busy", busy, 1);
    send_one(8'hC3, 1'b0);
    wait_done();
    chk("st_shift", n_shift, L);
    chk("st_done", n_done, 1);
    chk("st_left", q_exp.size(), 0);

    // start with abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_ready", in_ready, 0);
    @(negedge clk);
    chk("sa_ready2", in_ready, 0);
    chk("sa_cnt", bit_count, L);

`ifdef CONFIG_LOADER_READBACK_EN
    full_load(1'b0);
    rb_q.push_back(8'hA5);
    rb_q.push_back(8'hC0);
    rb_en = 1'b1;
    full_load(1'b0);
    chk("rb_left", rb_q.size(), 0);
    rb_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
